// File: rtl/pix_pack_fifo_pkg.sv
// Shared definitions for the pixel packer: register map, status/control bit positions,
// and the bus acknowledge state encoding.
package pix_pack_fifo_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

    localparam int unsigned ST_EMPTY   = 16;
    localparam int unsigned ST_FULL    = 17;
    localparam int unsigned ST_UNF     = 18;
    localparam int unsigned ST_C_LSB   = 20;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_FLUSH = 1;
    localparam int unsigned CTRL_CLR   = 2;

endpackage

// File: rtl/pix_pack_fifo_if.sv
// Pixel stream (valid/ready) plus picorv32 iomem slave bus, bundled for the packer block.
interface pix_pack_fifo_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output in_data, in_valid, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  in_ready, iomem_ready, iomem_rdata
    );

    modport slave (
        input  in_data, in_valid, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output in_ready, iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/pix_pack_fifo_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; level = wptr - rptr, flush empties it in one cycle.
module pix_pack_fifo_sync_fifo #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [WIDTH-1:0]      din_i,
    output logic [WIDTH-1:0]      dout_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int unsigned PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] CAPACITY = PW'(2 ** DEPTH_LOG2);

    logic [WIDTH-1:0] mem_q [2 ** DEPTH_LOG2];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign level_o = wptr_q - rptr_q;
    assign full_o  = (level_o == CAPACITY);
    assign empty_o = (level_o == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q[DEPTH_LOG2-1:0]];

    // NOTE: storage is not reset; the pointers alone decide which entries hold valid words.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= din_i;
    end

    // NOTE: sequential state uses <= so every register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_ONE;
            if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end
endmodule

// File: rtl/pix_pack_fifo.sv
// Packs four 8-bit pixels into little-endian 32-bit words, buffers them in a FIFO and
// exposes DATA/STATUS/CTRL registers on an iomem slave port, with a level interrupt.
module pix_pack_fifo
    import pix_pack_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int unsigned IRQ_LEVEL  = 8
) (
    input  logic           clk,
    input  logic           rst,
    pix_pack_fifo_if.slave bus,
    output logic           irq
);
    localparam int unsigned   LW         = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0] IRQ_THRESH = LW'(IRQ_LEVEL);

    bus_state_e    state_q, state_d;
    reg_sel_e      sel;
    logic          en_q, en_d, unf_q, unf_d, flush_q, flush_d, clr_q, clr_d, irq_q, irq_d;
    logic [1:0]    c_q, c_d;
    logic [23:0]   part_q, part_d;
    logic [31:0]   rdata_q, rdata_d, status_w, fifo_dout;
    logic [LW-1:0] level;
    logic          full, empty, push, pop, accept, req, rd, wr;
    logic          unused_bits;

    assign unused_bits = ^{bus.iomem_addr[1:0], bus.iomem_wdata[31:3], bus.iomem_wstrb[3:1]};

    assign bus.in_ready    = en_q && !full;
    assign bus.iomem_rdata = rdata_q;
    assign irq             = irq_q;

    assign accept = bus.in_valid && bus.in_ready;
    // A flush landing this cycle discards the pixel accepted alongside it.
    assign push   = accept && (c_q == 2'd3) && !flush_q;
    assign req    = bus.iomem_valid && (state_q == BUS_IDLE) &&
                    (bus.iomem_addr[31:4] == BASE_ADDR[31:4]);
    assign sel    = reg_sel_e'(bus.iomem_addr[3:2]);
    assign rd     = req && (bus.iomem_wstrb == 4'b0000);
    assign wr     = req && (bus.iomem_wstrb != 4'b0000);
    assign pop    = rd && (sel == REG_DATA) && !empty;
    assign irq_d  = en_q && (level >= IRQ_THRESH);

    pix_pack_fifo_sync_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush_q),
        .din_i   ({bus.in_data, part_q}),
        .dout_o  (fifo_dout),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= BUS_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every always_comb assigns its defaults first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: if (req) state_d = BUS_ACK;
            BUS_ACK:  state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    always_comb begin
        bus.iomem_ready = (state_q == BUS_ACK);
    end

    always_comb begin
        status_w                 = '0;
        status_w[LW-1:0]         = level;
        status_w[ST_EMPTY]       = empty;
        status_w[ST_FULL]        = full;
        status_w[ST_UNF]         = unf_q;
        status_w[ST_C_LSB +: 2]  = c_q;
    end

    always_comb begin
        en_d    = en_q;
        unf_d   = unf_q && !clr_q;
        flush_d = 1'b0;
        clr_d   = 1'b0;
        rdata_d = '0;
        if (rd) begin
            case (sel)
                REG_DATA:   if (empty) unf_d = 1'b1; else rdata_d = fifo_dout;
                REG_STATUS: rdata_d = status_w;
                REG_CTRL:   rdata_d = {31'b0, en_q};
                default:    rdata_d = '0;
            endcase
        end else if (wr && (sel == REG_CTRL) && bus.iomem_wstrb[0]) begin
            en_d    = bus.iomem_wdata[CTRL_EN];
            flush_d = bus.iomem_wdata[CTRL_FLUSH];
            clr_d   = bus.iomem_wdata[CTRL_CLR];
        end
    end

    // Lanes 0..2 are held here; lane 3 goes straight from in_data into the pushed word.
    always_comb begin
        c_d    = c_q;
        part_d = part_q;
        if (flush_q) begin
            c_d = 2'd0;
        end else if (accept) begin
            c_d = c_q + 2'd1;
            if (c_q != 2'd3) part_d[{c_q, 3'b000} +: 8] = bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= 1'b0;
            unf_q   <= 1'b0;
            flush_q <= 1'b0;
            clr_q   <= 1'b0;
            irq_q   <= 1'b0;
            c_q     <= 2'd0;
            part_q  <= '0;
            rdata_q <= '0;
        end else begin
            en_q    <= en_d;
            unf_q   <= unf_d;
            flush_q <= flush_d;
            clr_q   <= clr_d;
            irq_q   <= irq_d;
            c_q     <= c_d;
            part_q  <= part_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_pix_pack_fifo.sv
// Self-checking bench: a queue-based reference model tracks pixels, words, CTRL and the bus,
// alongside directed register checks and a randomized streaming run with a word scoreboard.
module tb_pix_pack_fifo;
    localparam logic [31:0] BASE       = 32'h0300_0000;
    localparam int          DEPTH      = 16;
    localparam int          IRQ_LVL    = 8;
    localparam logic [3:0]  OFF_DATA   = 4'h0;
    localparam logic [3:0]  OFF_STATUS = 4'h4;
    localparam logic [3:0]  OFF_CTRL   = 4'h8;
    localparam logic [3:0]  OFF_RSVD   = 4'hC;

    logic clk = 1'b0;
    logic rst;
    logic irq;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_on   = 1'b0;

    pix_pack_fifo_if bus ();

    pix_pack_fifo #(
        .DEPTH_LOG2 (4),
        .BASE_ADDR  (BASE),
        .IRQ_LEVEL  (IRQ_LVL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .irq (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: accepted-pixel queue for the partial word, word queue for the FIFO.
    logic [7:0]  m_pix[$];
    logic [31:0] m_words[$];
    bit          m_en, m_unf, m_irq, m_ack, m_flush_pend, m_clr_pend;
    logic [31:0] m_rdata;
    bit          m_acc, m_do_flush;
    int          m_lvl;

    task automatic model_reset();
        m_pix.delete();
        m_words.delete();
        m_en = 0; m_unf = 0; m_irq = 0; m_ack = 0;
        m_flush_pend = 0; m_clr_pend = 0; m_rdata = '0;
    endtask

    function automatic logic [31:0] model_status(int lvl);
        logic [31:0] s;
        s        = '0;
        s[4:0]   = 5'(lvl);
        s[16]    = (lvl == 0);
        s[17]    = (lvl == DEPTH);
        s[18]    = m_unf;
        s[21:20] = 2'(m_pix.size());
        return s;
    endfunction

    initial model_reset();

    always @(negedge clk) begin
        if (mon_on) begin
            check("in_ready", {31'b0, bus.in_ready}, {31'b0, m_en && (m_words.size() < DEPTH)});
            check("irq", {31'b0, irq}, {31'b0, m_irq});
            check("iomem_ready", {31'b0, bus.iomem_ready}, {31'b0, m_ack});
            if (m_ack) check("iomem_rdata", bus.iomem_rdata, m_rdata);
            if (rst) begin
                model_reset();
            end else begin
                m_lvl      = m_words.size();
                m_acc      = bus.in_valid && m_en && (m_lvl < DEPTH);
                m_do_flush = 0;
                m_irq      = m_en && (m_lvl >= IRQ_LVL);
                if (m_ack) begin
                    m_ack = 0;
                    m_do_flush = m_flush_pend;
                    if (m_clr_pend) m_unf = 0;
                    m_flush_pend = 0;
                    m_clr_pend = 0;
                end else if (bus.iomem_valid && bus.iomem_addr[31:4] == BASE[31:4]) begin
                    m_ack   = 1;
                    m_rdata = '0;
                    if (bus.iomem_wstrb == 4'b0000) begin
                        case (bus.iomem_addr[3:2])
                            2'd0: if (m_lvl == 0) m_unf = 1; else m_rdata = m_words.pop_front();
                            2'd1: m_rdata = model_status(m_lvl);
                            2'd2: m_rdata = {31'b0, m_en};
                            default: m_rdata = '0;
                        endcase
                    end else if (bus.iomem_addr[3:2] == 2'd2 && bus.iomem_wstrb[0]) begin
                        m_en         = bus.iomem_wdata[0];
                        m_flush_pend = bus.iomem_wdata[1];
                        m_clr_pend   = bus.iomem_wdata[2];
                    end
                end
                if (m_do_flush) begin
                    m_pix.delete();
                    m_words.delete();
                end else if (m_acc) begin
                    m_pix.push_back(bus.in_data);
                    if (m_pix.size() == 4) begin
                        m_words.push_back({m_pix[3], m_pix[2], m_pix[1], m_pix[0]});
                        m_pix.delete();
                    end
                end
            end
        end
    end

    task automatic bus_op(input logic [3:0] strb, input logic [3:0] off,
                          input logic [31:0] wdata, output logic [31:0] rdata);
        int n;
        bus.iomem_valid = 1'b1;
        bus.iomem_wstrb = strb;
        bus.iomem_addr  = BASE | {28'b0, off};
        bus.iomem_wdata = wdata;
        n = 0;
        @(posedge clk); #1;
        while (!bus.iomem_ready && n < 4) begin
            @(posedge clk); #1;
            n++;
        end
        check("bus_ack_latency", 32'(n), 32'd0);
        rdata = bus.iomem_rdata;
        @(posedge clk); #1;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'b0000;
    endtask

    task automatic send_pixel(input logic [7:0] d);
        int n;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("pixel_wait_bound", 32'(n >= 300), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        logic [31:0] r;
        for (int k = 0; k < n; k++) bus_op(4'b0000, OFF_DATA, '0, r);
    endtask

    logic [31:0] r;
    logic [31:0] sb_q[$];
    logic [7:0]  sb_pix[$];

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0;
        bus.iomem_valid = 1'b0; bus.iomem_wstrb = '0; bus.iomem_addr = '0; bus.iomem_wdata = '0;
        repeat (3) @(posedge clk);
        #1 mon_on = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rst_iomem_ready", {31'b0, bus.iomem_ready}, 32'd0);
        check("rst_rdata", bus.iomem_rdata, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);

        // Out-of-window request gets no acknowledge.
        bus.iomem_valid = 1'b1; bus.iomem_addr = BASE + 32'h10; bus.iomem_wstrb = 4'b0000;
        repeat (3) begin
            @(posedge clk); #1;
            check("oow_no_ack", {31'b0, bus.iomem_ready}, 32'd0);
        end
        bus.iomem_valid = 1'b0;
        @(posedge clk); #1;

        bus_op(4'b1111, OFF_CTRL, 32'h1, r);
        bus_op(4'b0000, OFF_CTRL, '0, r);
        check("ctrl_en_read", r, 32'h1);
        bus_op(4'b0010, OFF_CTRL, 32'h0, r);
        bus_op(4'b0000, OFF_CTRL, '0, r);
        check("ctrl_wstrb0_gate", r, 32'h1);

        // Basic packing order.
        send_pixel(8'h11); send_pixel(8'h22); send_pixel(8'h33); send_pixel(8'h44);
        bus_op(4'b0000, OFF_STATUS, '0, r);
        check("t1_status_lvl1", r, 32'h0000_0001);
        bus_op(4'b0000, OFF_DATA, '0, r);
        check("t1_data", r, 32'h4433_2211);
        bus_op(4'b0000, OFF_STATUS, '0, r);
        check("t1_status_empty", r, 32'h0001_0000);

        // Fill to full, then one pop frees space.
        for (int i = 0; i < 64; i++) send_pixel(8'(i));
        check("t2_in_ready_full", {31'b0, bus.in_ready}, 32'd0);
        bus_op(4'b0000, OFF_STATUS, '0, r);
        check("t2_status_full", r, 32'h0002_0010);
        bus_op(4'b0000, OFF_DATA, '0, r);
        check("t2_first_word", r, 32'h0302_0100);
        check("t2_in_ready_back", {31'b0, bus.in_ready}, 32'd1);
        for (int k = 1; k < 16; k++) begin
            bus_op(4'b0000, OFF_DATA, '0, r);
            check("t2_word", r, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        end

        // Underflow sticky and clear.
        bus_op(4'b0000, OFF_DATA, '0, r);
        check("t3_empty_read", r, 32'd0);
        bus_op(4'b0000, OFF_STATUS, '0, r);
        check("t3_unf_set", r, 32'h0005_0000);
        bus_op(4'b1111, OFF_CTRL, 32'h5, r);
        bus_op(4'b0000, OFF_STATUS, '0, r);
        check("t3_unf_clr", r, 32'h0001_0000);
        bus_op(4'b0000, OFF_CTRL, '0, r);
        check("t3_en_kept", r, 32'h1);
        bus_op(4'b0000, OFF_RSVD, '0, r);
        check("rsvd_read", r, 32'd0);

        // Flush drops a full word and a partial one.
        for (int i = 0; i < 6; i++) send_pixel(8'hAA + 8'(i));
        bus_op(4'b0000, OFF_STATUS, '0, r);
        check("t4_pre_flush", r, 32'h0020_0001);
        bus_op(4'b1111, OFF_CTRL, 32'h3, r);
        bus_op(4'b0000, OFF_STATUS, '0, r);
        check("t4_post_flush", r, 32'h0001_0000);
        send_pixel(8'h01); send_pixel(8'h02); send_pixel(8'h03); send_pixel(8'h04);
        bus_op(4'b0000, OFF_DATA, '0, r);
        check("t4_after_flush", r, 32'h0403_0201);

        // Interrupt threshold.
        for (int i = 0; i < 31; i++) send_pixel(8'(i));
        repeat (2) @(posedge clk);
        #1 check("t5_irq_lvl7", {31'b0, irq}, 32'd0);
        send_pixel(8'd31);
        check("t5_irq_same_cycle", {31'b0, irq}, 32'd0);
        @(posedge clk); #1;
        check("t5_irq_set", {31'b0, irq}, 32'd1);
        bus_op(4'b0000, OFF_DATA, '0, r);
        check("t5_word0", r, 32'h0302_0100);
        check("t5_irq_clr", {31'b0, irq}, 32'd0);
        drain(7);

        // Random stream with concurrent reads.
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [7:0] px;
                    px = 8'($urandom_range(0, 255));
                    send_pixel(px);
                    sb_pix.push_back(px);
                    if (sb_pix.size() == 4) begin
                        sb_q.push_back({sb_pix[3], sb_pix[2], sb_pix[1], sb_pix[0]});
                        sb_pix.delete();
                    end
                end
            end
            begin
                int got;
                int guard;
                logic [31:0] rr;
                got = 0;
                guard = 0;
                while (got < 50 && guard < 400) begin
                    repeat (10) @(posedge clk);
                    #1;
                    bus_op(4'b0000, OFF_STATUS, '0, rr);
                    if (rr[4:0] != 5'd0) begin
                        bus_op(4'b0000, OFF_DATA, '0, rr);
                        check("t6_sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                        if (sb_q.size() > 0) check("t6_stream_word", rr, sb_q.pop_front());
                        got++;
                    end
                    guard++;
                end
                check("t6_word_count", 32'(got), 32'd50);
            end
        join

        // Reset mid-stream with a bus request in flight.
        for (int i = 0; i < 40; i++) send_pixel(8'($urandom_range(0, 255)));
        @(posedge clk); #1;
        check("t6_irq_before_rst", {31'b0, irq}, 32'd1);
        bus.iomem_valid = 1'b1; bus.iomem_addr = BASE | {28'b0, OFF_DATA}; bus.iomem_wstrb = 4'b0000;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.iomem_valid = 1'b0;
        check("rst2_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rst2_iomem_ready", {31'b0, bus.iomem_ready}, 32'd0);
        check("rst2_rdata", bus.iomem_rdata, 32'd0);
        check("rst2_irq", {31'b0, irq}, 32'd0);
        @(posedge clk); #1;
        check("rst2_no_late_ack", {31'b0, bus.iomem_ready}, 32'd0);
        bus_op(4'b0000, OFF_STATUS, '0, r);
        check("rst2_status", r, 32'h0001_0000);
        bus_op(4'b0000, OFF_CTRL, '0, r);
        check("rst2_ctrl", r, 32'd0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
